// File: rtl/ddr2_sdram_if_ex_pattern_ctrl_if.sv
// Local (Avalon-style) request/response bus between the pattern sequencer and
// the DDR2 controller.
//   ready       : controller accepts the current request this cycle
//   write_req   : write request, data on wdata
//   read_req    : read request
//   address     : word address of the current request
//   wdata       : write data
//   rdata       : read data, qualified by rdata_valid
//   rdata_valid : rdata carries a returned word this cycle
// master = pattern sequencer side, slave = controller side.
interface ddr2_sdram_if_ex_pattern_ctrl_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 24
);
  logic              ready;
  logic              write_req;
  logic              read_req;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              rdata_valid;

  modport master (
    input  ready, rdata, rdata_valid,
    output write_req, read_req, address, wdata
  );

  modport slave (
    output ready, rdata, rdata_valid,
    input  write_req, read_req, address, wdata
  );
endinterface

// File: rtl/ddr2_sdram_if_ex_pattern_ctrl.sv
// Pattern sequencer for the DDR2 example driver's 8-bit LFSR lanes.
// One pass writes NUM_WORDS words taken from the write-generator LFSRs, reads
// them back and compares every returned word lane by lane against the checker
// LFSRs, keeping sticky per-lane pass/fail flags and a saturating error count.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   start, abort            begin a pass (IDLE/DONE only) / return to IDLE
//   gen_enable, gen_pause   write-generator LFSR control (enable low = reseed)
//   gen_data                write-generator LFSR outputs, one byte per lane
//   chk_enable, chk_pause   checker LFSR control (enable low = reseed)
//   chk_data                checker LFSR outputs, one byte per lane
//   local_bus               controller local interface (master side)
//   busy, test_complete     pass in progress / pass finished
//   pnf_per_byte, pass      sticky per-lane pass flags / overall pass in DONE
//   err_count               mismatching words, saturating
module ddr2_sdram_if_ex_pattern_ctrl #(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned ADDR_W    = 24,
  parameter int unsigned NUM_WORDS = 256,
  parameter int unsigned ADDR_BASE = 0,
  parameter int unsigned ERR_W     = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   abort,
  output logic                   gen_enable,
  output logic                   gen_pause,
  input  logic [8*NUM_LANES-1:0] gen_data,
  output logic                   chk_enable,
  output logic                   chk_pause,
  input  logic [8*NUM_LANES-1:0] chk_data,
  ddr2_sdram_if_ex_pattern_ctrl_if.master local_bus,
  output logic                   busy,
  output logic                   test_complete,
  output logic [NUM_LANES-1:0]   pnf_per_byte,
  output logic                   pass,
  output logic [ERR_W-1:0]       err_count
);

  localparam int unsigned CNT_W = $clog2(NUM_WORDS + 1);
  localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0]  ALL_WORDS = CNT_W'(NUM_WORDS);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(ADDR_BASE);

  typedef enum logic [2:0] {StIdle, StWrite, StRead, StWaitRd, StDone} state_e;

  state_e               state_q;
  logic [CNT_W-1:0]     wr_cnt_q;
  logic [CNT_W-1:0]     rq_cnt_q;
  logic [CNT_W-1:0]     rd_cnt_q;
  logic [ERR_W-1:0]     err_count_q;
  logic [NUM_LANES-1:0] pnf_q;

  logic                 wr_acc;
  logic                 rq_acc;
  logic                 rd_active;
  logic                 rd_acc;
  logic                 rd_done;
  logic [NUM_LANES-1:0] lane_err;

  assign wr_acc    = (state_q == StWrite) & local_bus.ready;
  assign rq_acc    = (state_q == StRead) & local_bus.ready;
  assign rd_active = (state_q == StRead) | (state_q == StWaitRd);
  // Returned data is only meaningful while a pass is reading back.
  assign rd_acc    = rd_active & local_bus.rdata_valid;
  // All words returned, counting a word that arrives on this very edge.
  assign rd_done   = (rd_cnt_q == ALL_WORDS) | (rd_acc & (rd_cnt_q == LAST_WORD));

  always_comb begin
    lane_err = '0;
    for (int i = 0; i < int'(NUM_LANES); i++) begin
      lane_err[i] = local_bus.rdata[8*i +: 8] != chk_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      wr_cnt_q    <= '0;
      rq_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      err_count_q <= '0;
      pnf_q       <= '1;
    end else if (abort) begin
      // Results are left as they were so a partial pass can still be inspected.
      state_q <= StIdle;
    end else begin
      if (rd_acc) begin
        rd_cnt_q <= rd_cnt_q + CNT_W'(1);
        pnf_q    <= pnf_q & ~lane_err;
        if ((|lane_err) && (err_count_q != '1)) begin
          err_count_q <= err_count_q + ERR_W'(1);
        end
      end
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q     <= StWrite;
            wr_cnt_q    <= '0;
            rq_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            err_count_q <= '0;
            pnf_q       <= '1;
          end
        end
        StWrite: begin
          if (wr_acc) begin
            wr_cnt_q <= wr_cnt_q + CNT_W'(1);
            if (wr_cnt_q == LAST_WORD) begin
              state_q <= StRead;
            end
          end
        end
        StRead: begin
          if (rq_acc) begin
            rq_cnt_q <= rq_cnt_q + CNT_W'(1);
            if (rq_cnt_q == LAST_WORD) begin
              state_q <= rd_done ? StDone : StWaitRd;
            end
          end
        end
        StWaitRd: begin
          if (rd_done) begin
            state_q <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    local_bus.write_req = (state_q == StWrite);
    local_bus.read_req  = (state_q == StRead);
    local_bus.address   = '0;
    if (state_q == StWrite) begin
      local_bus.address = BASE + ADDR_W'(wr_cnt_q);
    end else if (state_q == StRead) begin
      local_bus.address = BASE + ADDR_W'(rq_cnt_q);
    end
    local_bus.wdata = (state_q == StWrite) ? gen_data : '0;

    // Generator advances exactly once per accepted word; checker once per
    // returned word. Outside their phases both are held at their seeds.
    gen_enable = (state_q == StWrite);
    gen_pause  = ~wr_acc;
    chk_enable = rd_active;
    chk_pause  = ~rd_acc;

    busy          = (state_q == StWrite) | rd_active;
    test_complete = (state_q == StDone);
    pnf_per_byte  = pnf_q;
    err_count     = err_count_q;
    pass          = (state_q == StDone) & (&pnf_q);
  end

endmodule
